// File: rtl/expr_result_misr.sv
// expr_result_misr
// Compresses a stream of 90-bit expression result beats into a 32-bit
// signature with a CRC-32-polynomial MISR. After SAMPLES accepted beats the
// signature is held on sig_data until the consumer takes it, after which
// the MISR reloads SEED and a new accumulation starts.
//
// Parameters:
//   SAMPLES - accepted beats per signature (1..65535)
//   SEED    - MISR value after reset, clear and each signature hand-off
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high reset
//   clear     - synchronous restart of the current accumulation
//   in_valid  - result beat present
//   in_ready  - block accepts a beat this cycle (ACCUM state)
//   in_data   - 90-bit expression result vector
//   sig_valid - signature available (HOLD state)
//   sig_ready - consumer takes the signature
//   sig_data  - current MISR value / signature
//   sig_count - beats accepted in the current accumulation
//
// Optional feature (macro EXPR_MISR_COMPARE_EN):
//   golden    - expected signature
//   match     - sig_valid & (sig_data == golden), 0 during reset
module expr_result_misr #(
  parameter int unsigned SAMPLES = 16,
  parameter logic [31:0] SEED    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [89:0] in_data,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [31:0] sig_data,
`ifdef EXPR_MISR_COMPARE_EN
  output logic [15:0] sig_count,
  input  logic [31:0] golden,
  output logic        match
`else
  output logic [15:0] sig_count
`endif
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] misr_r, misr_next_s;
  logic [15:0] count_r, count_next_s;
  logic        accept_s;
  logic        last_beat_s;

  // XOR-fold the 90-bit beat down to 32 bits; the top 26 bits land in [25:0].
  function automatic logic [31:0] fold90(input logic [89:0] d);
    return d[31:0] ^ d[63:32] ^ {6'b00_0000, d[89:64]};
  endfunction

  // One MISR shift with CRC-32 feedback, then inject the folded beat.
  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] f);
    logic [31:0] fb;
    fb = m[31] ? 32'h04C1_1DB7 : 32'h0000_0000;
    return {m[30:0], 1'b0} ^ fb ^ f;
  endfunction

  assign in_ready    = (state_r == ACCUM);
  assign sig_valid   = (state_r == HOLD);
  assign sig_data    = misr_r;
  assign sig_count   = count_r;
  assign accept_s    = in_valid & in_ready;
  // The count reaching SAMPLES on this accept ends the accumulation.
  assign last_beat_s = ((count_r + 16'd1) == 16'(SAMPLES));

`ifdef EXPR_MISR_COMPARE_EN
  assign match = ~reset & sig_valid & (sig_data == golden);
`endif

  // Next-state, MISR and counter update; clear overrides everything.
  always_comb begin
    state_next_s = state_r;
    misr_next_s  = misr_r;
    count_next_s = count_r;
    case (state_r)
      ACCUM: begin
        if (accept_s) begin
          misr_next_s  = misr_step(misr_r, fold90(in_data));
          count_next_s = count_r + 16'd1;
          if (last_beat_s) begin
            state_next_s = HOLD;
          end else begin
            state_next_s = ACCUM;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      HOLD: begin
        if (sig_ready) begin
          state_next_s = ACCUM;
          misr_next_s  = SEED;
          count_next_s = 16'd0;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = ACCUM;
        misr_next_s  = SEED;
        count_next_s = 16'd0;
      end
    endcase
    if (clear) begin
      state_next_s = ACCUM;
      misr_next_s  = SEED;
      count_next_s = 16'd0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State, MISR and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ACCUM;
      misr_r  <= SEED;
      count_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      misr_r  <= misr_next_s;
      count_r <= count_next_s;
    end
  end

endmodule

// File: tb/tb_expr_result_misr.sv
module tb_expr_result_misr;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Instance A: SAMPLES=1, SEED=0
  logic        a_clear, a_in_valid, a_in_ready, a_sig_valid, a_sig_ready;
  logic [89:0] a_in_data;
  logic [31:0] a_sig_data;
  logic [15:0] a_sig_count;
`ifdef EXPR_MISR_COMPARE_EN
  logic [31:0] a_golden;
  logic        a_match;
`endif
  // Instance B: SAMPLES=2, SEED=0
  logic        b_clear, b_in_valid, b_in_ready, b_sig_valid, b_sig_ready;
  logic [89:0] b_in_data;
  logic [31:0] b_sig_data;
  logic [15:0] b_sig_count;
`ifdef EXPR_MISR_COMPARE_EN
  logic [31:0] b_golden;
  logic        b_match;
`endif
  // Instance C: default parameters
  logic        c_clear, c_in_valid, c_in_ready, c_sig_valid, c_sig_ready;
  logic [89:0] c_in_data;
  logic [31:0] c_sig_data;
  logic [15:0] c_sig_count;
`ifdef EXPR_MISR_COMPARE_EN
  logic [31:0] c_golden;
  logic        c_match;
`endif

  expr_result_misr #(.SAMPLES(1), .SEED(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .clear(a_clear), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .sig_valid(a_sig_valid),
    .sig_ready(a_sig_ready), .sig_data(a_sig_data),
`ifdef EXPR_MISR_COMPARE_EN
    .sig_count(a_sig_count), .golden(a_golden), .match(a_match)
`else
    .sig_count(a_sig_count)
`endif
  );

  expr_result_misr #(.SAMPLES(2), .SEED(32'h0000_0000)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .sig_valid(b_sig_valid),
    .sig_ready(b_sig_ready), .sig_data(b_sig_data),
`ifdef EXPR_MISR_COMPARE_EN
    .sig_count(b_sig_count), .golden(b_golden), .match(b_match)
`else
    .sig_count(b_sig_count)
`endif
  );

  expr_result_misr dut_c (
    .clk(clk), .reset(reset), .clear(c_clear), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_data(c_in_data), .sig_valid(c_sig_valid),
    .sig_ready(c_sig_ready), .sig_data(c_sig_data),
`ifdef EXPR_MISR_COMPARE_EN
    .sig_count(c_sig_count), .golden(c_golden), .match(c_match)
`else
    .sig_count(c_sig_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_clear = 1'b0; a_in_valid = 1'b0; a_sig_ready = 1'b0; a_in_data = '0;
    b_clear = 1'b0; b_in_valid = 1'b0; b_sig_ready = 1'b0; b_in_data = '0;
    c_clear = 1'b0; c_in_valid = 1'b0; c_sig_ready = 1'b0; c_in_data = '0;
`ifdef EXPR_MISR_COMPARE_EN
    a_golden = 32'h0; b_golden = 32'h0; c_golden = 32'h0;
`endif
    tick();
    tick();
    // Reset state
    chk("rst_a_valid", {31'd0, a_sig_valid}, 32'd0);
    chk("rst_a_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_a_data", a_sig_data, 32'h0);
    chk("rst_c_data", c_sig_data, 32'hFFFF_FFFF);
    chk("rst_c_count", {16'd0, c_sig_count}, 32'd0);
    reset = 1'b0;
    tick();

    // A: single beat 90'h1 -> signature 1
    a_in_valid = 1'b1; a_in_data = 90'h1;
    tick();
    a_in_valid = 1'b0; a_in_data = '0;
    chk("a1_valid", {31'd0, a_sig_valid}, 32'd1);
    chk("a1_data", a_sig_data, 32'h1);
    chk("a1_count", {16'd0, a_sig_count}, 32'd1);
    chk("a1_ready", {31'd0, a_in_ready}, 32'd0);
`ifdef EXPR_MISR_COMPARE_EN
    a_golden = 32'h1; #1;
    chk("a1_match1", {31'd0, a_match}, 32'd1);
    a_golden = 32'h2; #1;
    chk("a1_match0", {31'd0, a_match}, 32'd0);
`endif
    a_sig_ready = 1'b1;
    tick();
    a_sig_ready = 1'b0;
    chk("a1_handoff_data", a_sig_data, 32'h0);
    chk("a1_handoff_ready", {31'd0, a_in_ready}, 32'd1);

    // A: bit 64 folds into bit 0
    a_in_valid = 1'b1; a_in_data = 90'h1 << 64;
    tick();
    a_in_valid = 1'b0;
    chk("a2_data", a_sig_data, 32'h1);
    a_sig_ready = 1'b1;
    tick();
    a_sig_ready = 1'b0;

    // A: bits 0 and 32 cancel
    a_in_valid = 1'b1; a_in_data = (90'h1 << 32) | 90'h1;
    tick();
    a_in_valid = 1'b0;
    chk("a3_data", a_sig_data, 32'h0);
    chk("a3_valid", {31'd0, a_sig_valid}, 32'd1);
    a_sig_ready = 1'b1;
    tick();
    a_sig_ready = 1'b0;

    // A: bit 89 folds into bit 25
    a_in_valid = 1'b1; a_in_data = 90'h1 << 89;
    tick();
    a_in_valid = 1'b0;
    chk("a4_data", a_sig_data, 32'h0200_0000);
    // clear wins over a simultaneous hand-off
    a_clear = 1'b1; a_sig_ready = 1'b1;
    tick();
    a_clear = 1'b0; a_sig_ready = 1'b0;
    chk("a4_clr_valid", {31'd0, a_sig_valid}, 32'd0);
    chk("a4_clr_count", {16'd0, a_sig_count}, 32'd0);

    // B: beats 1 then 0 -> 2
    b_in_valid = 1'b1; b_in_data = 90'h1;
    tick();
    chk("b_mid_data", b_sig_data, 32'h1);
    chk("b_mid_ready", {31'd0, b_in_ready}, 32'd1);
    b_in_data = 90'h0;
    tick();
    chk("b_data", b_sig_data, 32'h2);
    chk("b_valid", {31'd0, b_sig_valid}, 32'd1);
    // HOLD stability with an upstream beat pending but not accepted
    b_in_data = 90'h3FF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_data", b_sig_data, 32'h2);
      chk("b_hold_count", {16'd0, b_sig_count}, 32'd2);
      chk("b_hold_ready", {31'd0, b_in_ready}, 32'd0);
    end
    b_in_valid = 1'b0;
    b_sig_ready = 1'b1;
    tick();
    b_sig_ready = 1'b0;
    chk("b_hand_data", b_sig_data, 32'h0);
    chk("b_hand_count", {16'd0, b_sig_count}, 32'd0);
    chk("b_hand_ready", {31'd0, b_in_ready}, 32'd1);

    // C: default parameters, 7 zero beats
    c_in_valid = 1'b1; c_in_data = '0;
    tick();
    chk("c_first_data", c_sig_data, 32'hFB3E_E249);
    chk("c_first_count", {16'd0, c_sig_count}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("c_seven_count", {16'd0, c_sig_count}, 32'd7);
    c_clear = 1'b1;
    tick();
    c_clear = 1'b0;
    chk("c_clr_count", {16'd0, c_sig_count}, 32'd0);
    chk("c_clr_data", c_sig_data, 32'hFFFF_FFFF);
    // Fill to HOLD, with in_valid kept high past the boundary
    for (int i = 0; i < 18; i++) tick();
    c_in_valid = 1'b0;
    chk("c_hold_valid", {31'd0, c_sig_valid}, 32'd1);
    chk("c_hold_count", {16'd0, c_sig_count}, 32'd16);
    // Asynchronous reset mid-HOLD, observed before the next edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("c_arst_valid", {31'd0, c_sig_valid}, 32'd0);
    chk("c_arst_data", c_sig_data, 32'hFFFF_FFFF);
    chk("c_arst_count", {16'd0, c_sig_count}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
